// File: rtl/pcm_out_stage.sv
// -----------------------------------------------------------------------------
// pcm_out_stage
//
// Final stage of the AAC filterbank datapath. It takes wide fixed-point samples
// from the overlap-add stage and turns each one into a PCM sample:
//   - rounds it half-up,
//   - arithmetic right shifts it by SHIFT,
//   - saturates it to OUT_W bits.
// Each sample is tagged with a frame-end marker. Results are buffered in a
// small FIFO so that a stalling PCM sink does not stall overlap-add on every
// cycle.
//
// Pipeline: input transfer -> S1 register -> FIFO (DEPTH entries) -> output.
//
// Ports
//   clk        single clock; all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   in_valid   overlap stage presents in_data
//   in_ready   block accepts in_data this cycle
//   in_data    IN_W-bit two's complement sample
//   out_valid  out_data / out_last are valid
//   out_ready  sink accepts the output this cycle
//   out_data   OUT_W-bit two's complement PCM sample
//   out_last   last sample of a FRAME_LEN-sample frame
//   clip_cnt   saturating count of clamped samples
// -----------------------------------------------------------------------------
module pcm_out_stage #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 15,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      clip_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [IN_W:0]      ROUND_C  = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [OUT_W-1:0]   SAT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   SAT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    // ---------------------------------------------------------------- state
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [OUT_W-1:0] s1_data_q,  s1_data_d;
    logic             s1_last_q,  s1_last_d;
    logic             s1_clip_q,  s1_clip_d;
    logic             s1_valid_q, s1_valid_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [15:0]      clip_cnt_q, clip_cnt_d;

    // FIFO storage: {last, data}; no reset needed because the outputs are
    // gated by out_valid.
    logic [OUT_W:0]   mem_q [DEPTH];
    logic [OUT_W:0]   head;

    // ---------------------------------------------------------- conversion
    logic [IN_W:0]    conv_r;
    logic [IN_W:0]    conv_q;
    logic [IN_W-OUT_W+1:0] conv_hi;
    logic [OUT_W-1:0] conv_data;
    logic             conv_clip;

    logic in_fire;
    logic out_fire;
    logic fifo_wr;

    always_comb begin
        // One guard bit above IN_W so that adding the rounding constant
        // cannot wrap at the positive extreme.
        conv_r  = {in_data[IN_W-1], in_data} + ROUND_C;
        conv_q  = $signed(conv_r) >>> SHIFT;
        // The value fits in OUT_W bits only if every bit from the OUT_W
        // sign position upward is a copy of the sign.
        conv_hi = conv_q[IN_W:OUT_W-1];
        conv_clip = !((&conv_hi) || !(|conv_hi));
        if (conv_clip) begin
            conv_data = conv_q[IN_W] ? SAT_MIN : SAT_MAX;
        end else begin
            conv_data = conv_q[OUT_W-1:0];
        end
    end

    // ---------------------------------------------------------- handshakes
    always_comb begin
        // Space is reserved for the sample sitting in S1. Because of this,
        // the FIFO write from S1 can never overflow. The result depends only
        // on registered state and rst, never on out_ready.
        in_ready  = !rst && ((count_q + CNT_W'(s1_valid_q)) < DEPTH_C);
        out_valid = (count_q != '0);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        fifo_wr   = s1_valid_q;
        head      = mem_q[rd_ptr_q];
        out_data  = out_valid ? head[OUT_W-1:0] : '0;
        out_last  = out_valid && head[OUT_W];
        clip_cnt  = clip_cnt_q;
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        idx_d      = idx_q;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        s1_clip_d  = s1_clip_q;
        s1_valid_d = in_fire;
        wr_ptr_d   = wr_ptr_q + PTR_W'(fifo_wr);
        rd_ptr_d   = rd_ptr_q + PTR_W'(out_fire);
        count_d    = count_q;
        clip_cnt_d = clip_cnt_q;

        if (in_fire) begin
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            s1_data_d = conv_data;
            s1_last_d = (idx_q == IDX_LAST);
            s1_clip_d = conv_clip;
        end

        // A simultaneous write and read cancel out.
        case ({fifo_wr, out_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (fifo_wr && s1_clip_q && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_d = clip_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            s1_data_q  <= '0;
            s1_last_q  <= 1'b0;
            s1_clip_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            clip_cnt_q <= '0;
        end else begin
            idx_q      <= idx_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
            s1_clip_q  <= s1_clip_d;
            s1_valid_q <= s1_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= {s1_last_q, s1_data_q};
        end
    end

endmodule

// File: tb/tb_pcm_out_stage.sv
module tb_pcm_out_stage;

    localparam int IN_W = 32, OUT_W = 16, SHIFT = 15, DEPTH = 8, FRAME_LEN = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_data;
    logic [15:0] out_data, clip_cnt;

    pcm_out_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH),
                    .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .clip_cnt(clip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] d; bit l; } exp_t;
    typedef struct { logic [31:0] din; logic [15:0] dout; } vec_t;

    exp_t        exp_q[$];
    int          vectors = 0, miscompares = 0;
    int          idx_m = 0;       // model frame position of next accepted sample
    int          exp_clip = 0;
    int          n_acc = 0, n_last = 0;
    bit          use_tab = 0;
    logic [15:0] tab_exp;
    bit          last_ov, last_ir;

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference conversion from the arithmetic definition:
    // floor((x + 2^(SHIFT-1)) / 2^SHIFT), clamped to the PCM range.
    function automatic void ref_conv(input logic [31:0] x, output logic [15:0] d, output bit c);
        longint v, q;
        v = longint'($signed(x));
        q = (v + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
        c = 1'b1;
        if (q > 32767)       d = 16'h7FFF;
        else if (q < -32768) d = 16'h8000;
        else begin d = q[15:0]; c = 1'b0; end
    endfunction

    // One clock: sample at the falling edge, update the scoreboard, then
    // return 1 time unit after the next rising edge.
    task automatic cycle();
        exp_t        e;
        logic [15:0] md;
        bit          mc;
        @(negedge clk);
        last_ov = out_valid;
        last_ir = in_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_last", out_last, exp_q[0].l);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (out_last) n_last++;
                end
            end
        end
        if (in_valid && in_ready) begin
            ref_conv(in_data, md, mc);
            e.d = use_tab ? tab_exp : md;
            e.l = (idx_m == FRAME_LEN-1);
            idx_m = (idx_m + 1) % FRAME_LEN;
            if (mc && exp_clip < 65535) exp_clip++;
            exp_q.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_sample();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'($signed($urandom_range(0, 32'h00FF_FFFF)) - 32'sh0080_0000);
            2:       return 32'h3FFF_8000 + 32'($urandom_range(0, 32'hFFFF));
            default: return 32'($signed($urandom_range(0, 32'h1FFF_FFFF)) - 32'sh1000_0000);
        endcase
    endfunction

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (k = 0; k < 100; k++) begin
            cycle();
            if (exp_q.size() == 0 && !last_ov) break;
        end
        if (k == 100) chk("drain_timeout", exp_q.size(), 0);
        // let the pipeline settle so clip_cnt reflects every written sample
        cycle();
    endtask

    // Accept n random samples with random stalls on both sides.
    task automatic feed(input int n, input int p_rdy, input int p_val);
        int target, k;
        target = n_acc + n;
        for (k = 0; k < 20000 && n_acc < target; k++) begin
            in_valid  = ($urandom_range(0, 99) < p_val);
            in_data   = rnd_sample();
            out_ready = ($urandom_range(0, 99) < p_rdy);
            cycle();
        end
        in_valid = 1'b0;
        if (n_acc < target) chk("feed_timeout", n_acc, target);
    endtask

    vec_t tab[7];

    initial begin
        tab[0] = '{32'h0000_4000, 16'd1};
        tab[1] = '{32'hFFFF_C000, 16'd0};
        tab[2] = '{32'h0000_3FFF, 16'd0};
        tab[3] = '{32'h0000_8000, 16'd1};
        tab[4] = '{32'h7FFF_FFFF, 16'h7FFF};
        tab[5] = '{32'h8000_0000, 16'h8000};
        tab[6] = '{32'h3FFF_C000, 16'h7FFF};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_clip_cnt", clip_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
        @(posedge clk); #1;

        // Rounding vectors; first one also measures latency.
        use_tab = 1;
        in_valid = 1'b1; in_data = tab[0].din; tab_exp = tab[0].dout;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("latency_n+1_out_valid", last_ov, 0);
        cycle();
        chk("latency_n+2_out_valid", last_ov, 1);
        for (int i = 1; i < 7; i++) begin
            in_valid = 1'b1; in_data = tab[i].din; tab_exp = tab[i].dout;
            cycle();
            if (i == 3) begin
                drain();
                chk("clip_cnt_rounding", clip_cnt, 0);
            end
        end
        drain();
        chk("clip_cnt_saturation", clip_cnt, 3);
        use_tab = 0;

        // Backpressure: only DEPTH samples fit while the sink is stalled.
        n_acc = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = rnd_sample();
            cycle();
        end
        chk("stall_accepted", n_acc, DEPTH);
        chk("stall_in_ready", last_ir, 0);
        // Full FIFO: read and offered write together; input stays closed
        // this cycle and reopens the next.
        out_ready = 1'b1; in_data = rnd_sample();
        cycle();
        chk("full_rw_in_ready", last_ir, 0);
        out_ready = 1'b0; in_data = rnd_sample();
        cycle();
        chk("reopen_in_ready", last_ir, 1);
        in_valid = 1'b0;
        drain();

        // Frame tagging over two frames from a fresh reset.
        rst = 1'b1; #2; rst = 1'b0;
        exp_q.delete(); idx_m = 0; exp_clip = 0; n_last = 0;
        @(posedge clk); #1;
        feed(2048, 70, 80);
        drain();
        chk("frame_last_count", n_last, 2);
        chk("clip_cnt_random", clip_cnt, exp_clip);

        // Reset mid-frame with the FIFO partly filled.
        feed(496, 100, 100);
        feed(4, 0, 100);
        chk("pre_reset_idx", idx_m, 500);
        #1; rst = 1'b1; #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_clip_cnt", clip_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        exp_q.delete(); idx_m = 0; exp_clip = 0; n_last = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        feed(1024, 60, 90);
        drain();
        chk("post_reset_last_count", n_last, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
